// File: rtl/csa_resolver_pkg.sv
// Shared types and helpers for the carry-save resolver: FSM states, default widths,
// the result-width helper and the single-bit full-adder cell used by the ripple slice.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_W     = 4;
  localparam int DEF_CHUNK = 1;

  // A carry-save pair of width w resolves into at most w+2 bits.
  function automatic int res_width(input int w);
    return w + 2;
  endfunction

  // Returns {cout, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/csa_resolver_slice.sv
// CHUNK-bit combinational ripple-carry slice built from the package full-adder cell.
module csa_resolve_slice
  import csa_pkg::*;
#(
  parameter int N = DEF_CHUNK
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Ripple the carry through the chunk with a block-local carry variable.
  always_comb begin : ripple
    logic w_c;
    logic [1:0] w_fa;
    w_c  = cin;
    sum  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_fa   = full_add(a[i], b[i], w_c);
      sum[i] = w_fa[0];
      w_c    = w_fa[1];
    end
    cout = w_c;
  end

endmodule

// File: rtl/csa_resolver.sv
// Multi-cycle carry-save to binary resolver, CHUNK bits per cycle, valid/ready on both sides.
// Optional build macro CSA_RESOLVER_FASTPATH_EN: a zero carry vector skips RESOLVE.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              csa_s,
  input  logic [W-1:0]              csa_co,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [res_width(W)-1:0]   out_sum
);

  localparam int             IW       = $clog2(W) + 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(W - CHUNK);
  localparam logic [IW-1:0]  STEP     = IW'(CHUNK);

  state_t                    r_state;
  state_t                    w_next;
  logic [W-1:0]              r_a;
  logic [W-1:0]              r_b;
  logic                      r_carry;
  logic [IW-1:0]             r_idx;
  logic [res_width(W)-1:0]   r_sum;
  logic [CHUNK-1:0]          w_chunk_sum;
  logic                      w_chunk_cout;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_fast;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == LAST_IDX);

`ifdef CSA_RESOLVER_FASTPATH_EN
  assign w_fast = (csa_co == {W{1'b0}});
`else
  assign w_fast = 1'b0;
`endif

  csa_resolve_slice #(.N(CHUNK)) u_slice (
    .a    (r_a[r_idx +: CHUNK]),
    .b    (r_b[r_idx +: CHUNK]),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_chunk_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? DONE : RESOLVE; else w_next = IDLE;
      RESOLVE: if (w_last)   w_next = DONE;                    else w_next = RESOLVE;
      DONE:    if (out_ready) w_next = IDLE;                   else w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and chunked accumulation; {0,0,csa_s} is already the fast-path result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= {IW{1'b0}};
      r_sum   <= {res_width(W){1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= csa_s >> 1;
            r_b     <= csa_co;
            r_carry <= 1'b0;
            r_idx   <= {IW{1'b0}};
            r_sum   <= {2'b00, csa_s};
          end
        end
        RESOLVE: begin
          r_sum[int'(r_idx) + 1 +: CHUNK] <= w_chunk_sum;
          r_carry                         <= w_chunk_cout;
          r_idx                           <= r_idx + STEP;
          if (w_last) begin
            r_sum[W+1] <= w_chunk_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver at W=4 with CHUNK=1, 2 and 4 instances side by side.
module tb_csa_resolver;

  logic        clk;
  logic        rst_n;
  logic [3:0]  csa_s;
  logic [3:0]  csa_co;
  logic        out_ready;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [5:0]  out_sum_v [3];

  int          n_checks;
  int          n_pass;
  logic [5:0]  sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csa_resolver #(.W(4), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .csa_s(csa_s), .csa_co(csa_co), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_sum(out_sum_v[0]));

  csa_resolver #(.W(4), .CHUNK(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .csa_s(csa_s), .csa_co(csa_co), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_sum(out_sum_v[1]));

  csa_resolver #(.W(4), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .csa_s(csa_s), .csa_co(csa_co), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_sum(out_sum_v[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One transaction on instance sel; hold>0 stalls out_ready for that many cycles in DONE.
  task automatic do_op(input int sel, input logic [3:0] s, input logic [3:0] co, input int hold);
    int         lat;
    int         exp_lat;
    logic [5:0] held;
    exp_lat = (sel == 0) ? 4 : (sel == 1) ? 2 : 1;
`ifdef CSA_RESOLVER_FASTPATH_EN
    if (co == 4'd0) exp_lat = 1;
`endif
    @(negedge clk);
    check_val("in_ready_idle", in_ready_v[sel], 1);
    csa_s          = s;
    csa_co         = co;
    in_valid_v[sel] = 1'b1;
    out_ready      = (hold == 0);
    sb_q.push_back({2'b00, s} + {1'b0, co, 1'b0});
    @(posedge clk);
    #1;
    in_valid_v[sel] = 1'b0;
    csa_s          = ~s;
    csa_co         = ~co;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid_v[sel]) break;
      @(posedge clk);
      lat++;
    end
    check_val("latency", lat, exp_lat);
    if (hold > 0) begin
      held = out_sum_v[sel];
      repeat (hold) begin
        in_valid_v[sel] = 1'b1;
        csa_s = 4'hF;
        csa_co = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check_val("hold_sum", out_sum_v[sel], held);
        check_val("hold_valid", out_valid_v[sel], 1);
        check_val("hold_in_ready", in_ready_v[sel], 0);
      end
      in_valid_v[sel] = 1'b0;
      out_ready = 1'b1;
    end
    check_val("sum", out_sum_v[sel], sb_q.pop_front());
    if (hold > 0) begin
      repeat (2) @(negedge clk);
      check_val("no_capture_valid", out_valid_v[sel], 0);
      check_val("no_capture_ready", in_ready_v[sel], 1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    in_valid_v = 3'b000;
    out_ready  = 1'b1;
    csa_s      = 4'h0;
    csa_co     = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_val("rst_in_ready", in_ready_v[k], 1);
      check_val("rst_out_valid", out_valid_v[k], 0);
      check_val("rst_out_sum", out_sum_v[k], 0);
    end

    do_op(0, 4'b0101, 4'b0011, 0);
    do_op(0, 4'b1111, 4'b1111, 0);
    do_op(2, 4'b1001, 4'b0111, 0);
    do_op(2, 4'b1111, 4'b1111, 0);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      do_op(1, v[3:0], v[7:4], (i == 77) ? 3 : 0);
    end

    // Reset during the second RESOLVE cycle of the CHUNK=1 instance.
    @(negedge clk);
    csa_s = 4'b0101;
    csa_co = 4'b0011;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("midrst_out_valid", out_valid_v[0], 0);
    check_val("midrst_in_ready", in_ready_v[0], 1);
    check_val("midrst_out_sum", out_sum_v[0], 0);
    repeat (4) @(negedge clk);
    check_val("midrst_no_output", out_valid_v[0], 0);
    do_op(0, 4'b0001, 4'b0001, 0);

    do_op(0, 4'b1010, 4'b0000, 0);
    do_op(1, 4'b1010, 4'b0000, 0);
    do_op(2, 4'b1010, 4'b0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
